random_health_monitor: RTL and testbench
========================================

RANDOM_HEALTH_MONITOR -- requirements
Module: random_health_monitor

Interface
REQ-001 SHALL have parameter Width, default 32, which is the random word width in bits.
REQ-002 SHALL have parameter WindowWords, default 64, which is the number of words per test window (power of two, >= 2).
REQ-003 SHALL have parameter OnesTol, default 128, which is the maximum allowed |ones - Width*WindowWords/2|.
REQ-004 SHALL have parameter MaxRun, default 34, which is the maximum allowed length of a run of identical bits.
REQ-005 SHALL derive CntW = clog2(Width*WindowWords+1) locally; it SHALL NOT be overridable.
REQ-006 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: begin a new test window.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data holds a random word.
REQ-010 SHALL have port in_data, input, Width bits: random word under test.
REQ-011 SHALL have port in_ready, output, 1 bit: the monitor accepts a word this cycle.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-014 SHALL have port pass, output, 1 bit: verdict of the last completed window.
REQ-015 SHALL have port ones_count, output, CntW bits: ones counted in the last window.
REQ-016 SHALL have port longest_run, output, CntW bits: longest same-bit run in the last window.

Function
REQ-017 SHALL implement an FSM with states IDLE, COLLECT, EVAL and REPORT.
REQ-018 IDLE: when start=1, the FSM SHALL go to COLLECT and clear the word counter, ones accumulator, current run, longest run and last_bit.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 in_ready SHALL be 1 only in COLLECT; words offered in any other state SHALL be ignored.
REQ-021 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; idle cycles (in_valid=0) SHALL leave all accumulators unchanged.
REQ-022 On each transfer, the ones accumulator SHALL increase by popcount(in_data); it SHALL be CntW bits wide and can never overflow.
REQ-023 Run tracking SHALL scan bits in order bit0..bit(Width-1), and runs SHALL continue across word boundaries.
REQ-024 The first bit of a window SHALL start a run of length 1.
REQ-025 For each later bit: if it equals last_bit, cur_run SHALL be incremented; otherwise cur_run SHALL be set to 1.
REQ-026 longest SHALL be max(longest, cur_run), evaluated after every bit.
REQ-027 The run update SHALL process a whole word in the transfer cycle (combinational scan) and then register last_bit = in_data[Width-1].
REQ-028 After the WindowWords-th transfer, the FSM SHALL go to EVAL in the next cycle; in_ready SHALL be 0 in EVAL.
REQ-029 EVAL (one cycle) SHALL register ones_count and longest_run, and set pass = (|ones - Width*WindowWords/2| <= OnesTol) AND (longest <= MaxRun).
REQ-030 The magnitude computation SHALL use CntW+1-bit signed arithmetic.
REQ-031 REPORT (one cycle) SHALL drive done=1, then the FSM SHALL return to IDLE.
REQ-032 Latency: last transfer at cycle N, EVAL at N+1, done=1 at N+2.
REQ-033 pass, ones_count and longest_run SHALL hold their values until the next EVAL; they SHALL NOT change while a new window is collecting.
REQ-034 busy SHALL be 1 in COLLECT, EVAL and REPORT.
REQ-035 Simultaneous start and done (in REPORT) SHALL NOT start a new window; start SHALL be re-asserted in IDLE.

Reset
REQ-036 While rst=1, the FSM SHALL be in IDLE; in_ready, busy, done and pass SHALL be 0; ones_count and longest_run SHALL be 0; all internal accumulators and counters SHALL be 0.
REQ-037 rst asserted mid-window SHALL abort the window without a done pulse; the previous results SHALL be cleared to 0.
REQ-038 Operation after rst deassertion SHALL require a fresh start.

Verification (Width=32, WindowWords=64, OnesTol=128, MaxRun=34)
REQ-039 start, then 64 x 0x55555555 back-to-back: required result is ones_count=1024, longest_run=1, pass=1, and done exactly 2 cycles after the last transfer, for one cycle.
REQ-040 start, then 64 x 0xFFFFFFFF: required result is ones_count=2048, longest_run=2048, pass=0.
REQ-041 start, then words alternating 0x00000000/0xFFFFFFFF: required result is longest_run=32, ones=1024, pass=1; repeating the pattern 0xFFFFFFFF,0xFFFFFFFF,0,0 instead SHALL give longest_run=64, pass=0.
REQ-042 Tolerance boundary, 16 x 0x77777777 + 48 x 0x55555555: required result is ones=1152, longest_run=3, pass=1; with 17 + 47 words the required result is ones=1160, pass=0.
REQ-043 Random in_valid gaps, plus words offered in IDLE and REPORT: required result is counts identical to the gap-free run, with in_ready=0 outside COLLECT.
REQ-044 rst after 10 transfers: required result is no done, all outputs 0; a new start with 64 x 0x55555555 SHALL give ones_count=1024, pass=1.

Source files
------------

// File: rtl/random_health_monitor.sv
// Online health monitor for a random word stream: counts ones and tracks the
// longest same-bit run over a window of words, then reports a pass/fail verdict.
module random_health_monitor #(
  parameter int Width       = 32,
  parameter int WindowWords = 64,
  parameter int OnesTol     = 128,
  parameter int MaxRun      = 34,
  localparam int CntW       = $clog2(Width * WindowWords + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CntW-1:0]  ones_count,
  output logic [CntW-1:0]  longest_run
);

  localparam int WcW = $clog2(WindowWords);
  localparam logic signed [CntW:0] HalfS   = (CntW + 1)'(Width * WindowWords / 2);
  localparam logic        [CntW:0] TolU    = (CntW + 1)'(OnesTol);
  localparam logic      [CntW-1:0] MaxRunU = CntW'(MaxRun);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, REPORT} state_t;

  state_t          state_q, state_d;
  logic [WcW-1:0]  word_cnt_q, word_cnt_d;
  logic [CntW-1:0] ones_acc_q, ones_acc_d;
  logic [CntW-1:0] cur_run_q, cur_run_d;
  logic [CntW-1:0] longest_q, longest_d;
  logic            last_bit_q, last_bit_d;
  logic [CntW-1:0] ones_count_q, ones_count_d;
  logic [CntW-1:0] longest_run_q, longest_run_d;
  logic            pass_q, pass_d;

  logic [CntW-1:0] word_ones, scan_run, scan_longest;
  logic signed [CntW:0] ones_diff;
  logic        [CntW:0] ones_mag;
  logic            xfer;

  assign in_ready    = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == REPORT);
  assign pass        = pass_q;
  assign ones_count  = ones_count_q;
  assign longest_run = longest_run_q;
  assign xfer        = in_valid && in_ready;

  // Whole-word scan in one cycle; the run carries over from the previous word
  // except for the very first bit of a window.
  always_comb begin : scan
    logic prev_bit;
    word_ones    = '0;
    scan_run     = cur_run_q;
    scan_longest = longest_q;
    prev_bit     = last_bit_q;
    for (int i = 0; i < Width; i++) begin
      word_ones = word_ones + CntW'(in_data[i]);
      if ((i == 0) && (word_cnt_q == '0)) begin
        scan_run = CntW'(1);
      end else if (in_data[i] == prev_bit) begin
        scan_run = scan_run + CntW'(1);
      end else begin
        scan_run = CntW'(1);
      end
      if (scan_run > scan_longest) begin
        scan_longest = scan_run;
      end
      prev_bit = in_data[i];
    end
  end

  always_comb begin
    ones_diff = $signed({1'b0, ones_acc_q}) - HalfS;
    ones_mag  = ones_diff[CntW] ? $unsigned(-ones_diff) : $unsigned(ones_diff);
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    ones_acc_d    = ones_acc_q;
    cur_run_d     = cur_run_q;
    longest_d     = longest_q;
    last_bit_d    = last_bit_q;
    ones_count_d  = ones_count_q;
    longest_run_d = longest_run_q;
    pass_d        = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          word_cnt_d = '0;
          ones_acc_d = '0;
          cur_run_d  = '0;
          longest_d  = '0;
          last_bit_d = 1'b0;
        end
      end
      COLLECT: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + WcW'(1);
          ones_acc_d = ones_acc_q + word_ones;
          cur_run_d  = scan_run;
          longest_d  = scan_longest;
          last_bit_d = in_data[Width-1];
          if (word_cnt_q == WcW'(WindowWords - 1)) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        ones_count_d  = ones_acc_q;
        longest_run_d = longest_q;
        pass_d        = (ones_mag <= TolU) && (longest_q <= MaxRunU);
        state_d       = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      ones_acc_q    <= '0;
      cur_run_q     <= '0;
      longest_q     <= '0;
      last_bit_q    <= 1'b0;
      ones_count_q  <= '0;
      longest_run_q <= '0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      ones_acc_q    <= ones_acc_d;
      cur_run_q     <= cur_run_d;
      longest_q     <= longest_d;
      last_bit_q    <= last_bit_d;
      ones_count_q  <= ones_count_d;
      longest_run_q <= longest_run_d;
      pass_q        <= pass_d;
    end
  end

endmodule

// File: tb/tb_random_health_monitor.sv
// Self-checking bench for random_health_monitor: directed windows with fixed
// expectations, plus random windows checked against a bit-stream reference model.
module tb_random_health_monitor;

  localparam int W  = 32;
  localparam int N  = 64;
  localparam int CW = $clog2(W * N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, busy, done, pass;
  logic [CW-1:0] ones_count, longest_run;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] win_words [N];
  int r_ones, r_long, r_pass, r_lat, r_after_done, r_busy_after, r_ready_viol, r_hold_viol;
  int m_ones, m_long, m_pass;

  random_health_monitor #(.Width(W), .WindowWords(N), .OnesTol(128), .MaxRun(34)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .ones_count(ones_count), .longest_run(longest_run)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Treat the window as one long bit stream (word 0 bit 0 first) and measure it.
  function automatic void model();
    int run, diff;
    logic prev, b;
    m_ones = 0; m_long = 0; run = 0; prev = 1'b0;
    for (int w = 0; w < N; w++) begin
      for (int k = 0; k < W; k++) begin
        b = win_words[w][k];
        m_ones += int'(b);
        run = (run != 0 && b == prev) ? run + 1 : 1;
        prev = b;
        if (run > m_long) m_long = run;
      end
    end
    diff = m_ones - (W * N / 2);
    if (diff < 0) diff = -diff;
    m_pass = (diff <= 128 && m_long <= 34) ? 1 : 0;
  endfunction

  // Stimulus driver: runs one window from IDLE to back in IDLE and records what it saw.
  task automatic run_window(input bit gaps, input bit junk);
    int idx, budget, lat;
    logic [CW-1:0] h_ones, h_long;
    logic h_pass;
    r_ready_viol = 0; r_hold_viol = 0; r_busy_after = 0;
    h_ones = ones_count; h_long = longest_run; h_pass = pass;
    if (junk) begin
      repeat (2) begin
        in_valid = 1'b1; in_data = $urandom;
        if (in_ready !== 1'b0) r_ready_viol++;
        @(posedge clk); #1;
      end
    end
    start = 1'b1; in_valid = junk; in_data = $urandom;
    if (in_ready !== 1'b0) r_ready_viol++;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; budget = 0;
    while (idx < N && budget < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? win_words[idx] : $urandom;
      if (in_ready !== 1'b1) r_ready_viol++;
      if (ones_count !== h_ones || longest_run !== h_long || pass !== h_pass) r_hold_viol++;
      @(posedge clk); #1;
      if (in_valid) idx++;
      budget++;
    end
    in_valid = junk; in_data = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) r_ready_viol++;
      @(posedge clk); #1;
      in_data = $urandom;
      lat++;
    end
    r_lat  = (done === 1'b1) ? lat : -1;
    r_ones = int'(ones_count); r_long = int'(longest_run); r_pass = int'(pass);
    if (in_ready !== 1'b0) r_ready_viol++;
    start = junk;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    r_after_done = int'(done);
    if (busy !== 1'b0) r_busy_after = 1;
    @(posedge clk); #1;
    if (busy !== 1'b0) r_busy_after = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: busy=%b in_ready=%b done=%b, required 0/0/0", busy, in_ready, done);
    end
    n_cmp++; if (pass !== 1'b0 || ones_count !== '0 || longest_run !== '0) begin
      n_bad++; $display("FAIL reset_results: pass=%b ones=%0d longest=%0d, required 0/0/0", pass, ones_count, longest_run);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_autostart: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_directed();
    int exp_ones [6] = '{1024, 2048, 1024, 1024, 1152, 1160};
    int exp_long [6] = '{1, 2048, 32, 64, 3, 3};
    int exp_pass [6] = '{1, 0, 1, 0, 1, 0};
    for (int id = 0; id < 6; id++) begin
      for (int i = 0; i < N; i++) begin
        case (id)
          0: win_words[i] = 32'h5555_5555;
          1: win_words[i] = 32'hFFFF_FFFF;
          2: win_words[i] = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
          3: win_words[i] = (i % 4 < 2) ? 32'hFFFF_FFFF : 32'h0;
          4: win_words[i] = (i < 16) ? 32'h7777_7777 : 32'h5555_5555;
          default: win_words[i] = (i < 17) ? 32'h7777_7777 : 32'h5555_5555;
        endcase
      end
      run_window(1'b0, id != 0);
      $display("directed %0d: ones=%0d longest=%0d pass=%0d latency=%0d", id, r_ones, r_long, r_pass, r_lat);
      n_cmp++; if (r_ones != exp_ones[id]) begin
        n_bad++; $display("FAIL dir%0d_ones: got %0d required %0d", id, r_ones, exp_ones[id]);
      end
      n_cmp++; if (r_long != exp_long[id]) begin
        n_bad++; $display("FAIL dir%0d_longest: got %0d required %0d", id, r_long, exp_long[id]);
      end
      n_cmp++; if (r_pass != exp_pass[id]) begin
        n_bad++; $display("FAIL dir%0d_pass: got %0d required %0d", id, r_pass, exp_pass[id]);
      end
      n_cmp++; if (r_lat != 2 || r_after_done != 0) begin
        n_bad++; $display("FAIL dir%0d_done_timing: latency %0d width_extra %0d, required 2 and 0", id, r_lat, r_after_done);
      end
      n_cmp++; if (r_ready_viol != 0 || r_hold_viol != 0 || r_busy_after != 0) begin
        n_bad++; $display("FAIL dir%0d_protocol: ready_err %0d hold_err %0d busy_after %0d, required 0/0/0",
                          id, r_ready_viol, r_hold_viol, r_busy_after);
      end
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) begin
        win_words[i] = (it == 1) ? ($urandom & $urandom) : $urandom;
        if (it == 3 && i == 20) win_words[i] = 32'hFFFF_FFF0;
        if (it == 3 && i == 21) win_words[i] = 32'h0000_003F;
      end
      model();
      for (int pass_no = 0; pass_no < 2; pass_no++) begin
        run_window(pass_no == 0, pass_no == 0);
        $display("random %0d/%0d: ones=%0d/%0d longest=%0d/%0d pass=%0d/%0d",
                 it, pass_no, r_ones, m_ones, r_long, m_long, r_pass, m_pass);
        n_cmp++; if (r_ones != m_ones || r_long != m_long || r_pass != m_pass) begin
          n_bad++; $display("FAIL rnd%0d_%0d_result: got ones %0d longest %0d pass %0d, required %0d %0d %0d",
                            it, pass_no, r_ones, r_long, r_pass, m_ones, m_long, m_pass);
        end
        n_cmp++; if (r_lat != 2 || r_after_done != 0 || r_busy_after != 0) begin
          n_bad++; $display("FAIL rnd%0d_%0d_timing: latency %0d done_after %0d busy_after %0d, required 2/0/0",
                            it, pass_no, r_lat, r_after_done, r_busy_after);
        end
        n_cmp++; if (r_ready_viol != 0 || r_hold_viol != 0) begin
          n_bad++; $display("FAIL rnd%0d_%0d_protocol: ready_err %0d hold_err %0d, required 0/0",
                            it, pass_no, r_ready_viol, r_hold_viol);
        end
      end
    end
  endtask

  task automatic test_abort_reset();
    int seen_done;
    for (int i = 0; i < N; i++) win_words[i] = 32'h5555_5555;
    seen_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h5555_5555;
    repeat (10) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
                 ones_count !== '0 || longest_run !== '0) begin
      n_bad++; $display("FAIL abort_clear: busy=%b rdy=%b done=%b pass=%b ones=%0d longest=%0d, required all 0",
                        busy, in_ready, done, pass, ones_count, longest_run);
    end
    repeat (2) begin @(posedge clk); #1; if (done !== 1'b0) seen_done = 1; end
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) seen_done = 1; end
    n_cmp++; if (seen_done != 0) begin
      n_bad++; $display("FAIL abort_quiet: done/busy activity seen %0d, required 0", seen_done);
    end
    run_window(1'b0, 1'b0);
    $display("after abort: ones=%0d longest=%0d pass=%0d", r_ones, r_long, r_pass);
    n_cmp++; if (r_ones != 1024 || r_pass != 1 || r_long != 1 || r_lat != 2) begin
      n_bad++; $display("FAIL abort_restart: got ones %0d pass %0d longest %0d latency %0d, required 1024 1 1 2",
                        r_ones, r_pass, r_long, r_lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_gaps();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
